// File: rtl/chacha20_pkg.sv
// Shared types and constants for the ChaCha20 keystream receive path.
package chacha20_pkg;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Word i occupies bits [32*i+31 : 32*i] of a keystream block.
    function automatic logic [WORD_W-1:0] block_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [IDX_W-1:0]   idx
    );
        return blk[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/chacha20_word_select.sv
// Selects one 32-bit keystream word from the buffered 512-bit block.
module chacha20_word_select
    import chacha20_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk,
    input  logic [IDX_W-1:0]   idx,
    output logic [WORD_W-1:0]  word
);

    assign word = block_word(blk, idx);

endmodule

// File: rtl/chacha20_stream_decryptor.sv
// XORs a buffered ChaCha20 keystream block into a 32-bit ciphertext stream.
// Optional build macro CHACHA20_DECRYPT_ZEROIZE_EN wipes the buffer whenever the block is released.
module chacha20_stream_decryptor
    import chacha20_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int WORD_W          = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clear,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0] ks_block,
    input  logic                              ks_valid,
    output logic                              ks_ready,
    input  logic [WORD_W-1:0]                 ct_data,
    input  logic                              ct_last,
    input  logic                              ct_valid,
    output logic                              ct_ready,
    output logic [WORD_W-1:0]                 pt_data,
    output logic                              pt_last,
    output logic                              pt_valid,
    input  logic                              pt_ready,
    output logic [31:0]                       blocks_used
);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             word_idx_q, word_idx_d;
    logic [BLOCK_W-1:0]           buf_q, buf_d;
    logic [WORD_W-1:0]            pt_data_q, pt_data_d;
    logic                         pt_last_q, pt_last_d;
    logic                         pt_valid_q, pt_valid_d;
    logic [31:0]                  blocks_used_q, blocks_used_d;
    logic [WORD_W-1:0]            ks_word;
    logic                         ks_hs;
    logic                         ct_hs;

    chacha20_word_select u_word_select (
        .blk  (buf_q),
        .idx  (word_idx_q),
        .word (ks_word)
    );

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        buf_d         = buf_q;
        pt_data_d     = pt_data_q;
        pt_last_d     = pt_last_q;
        pt_valid_d    = pt_valid_q;
        blocks_used_d = blocks_used_q;

        ks_ready = (state_q == EMPTY);
        ct_ready = (state_q == ACTIVE) && (!pt_valid_q || pt_ready);
        ks_hs    = ks_valid && ks_ready;
        ct_hs    = ct_valid && ct_ready;

        // A consumed word is dropped unless a new one replaces it below.
        if (pt_ready) begin
            pt_valid_d = 1'b0;
        end

        case (state_q)
            EMPTY: begin
                if (ks_hs) begin
                    buf_d         = ks_block;
                    word_idx_d    = '0;
                    blocks_used_d = blocks_used_q + 32'd1;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ct_hs) begin
                    pt_data_d  = ct_data ^ ks_word;
                    pt_last_d  = ct_last;
                    pt_valid_d = 1'b1;
                    // A message end forfeits the rest of the block.
                    if (ct_last || (word_idx_q == IDX_W'(WORDS_PER_BLOCK - 1))) begin
                        state_d    = EMPTY;
                        word_idx_d = '0;
`ifdef CHACHA20_DECRYPT_ZEROIZE_EN
                        buf_d      = '0;
`else
                        buf_d      = buf_q;
`endif
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_q       <= EMPTY;
            word_idx_q    <= '0;
            buf_q         <= '0;
            pt_data_q     <= '0;
            pt_last_q     <= 1'b0;
            pt_valid_q    <= 1'b0;
            blocks_used_q <= '0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            buf_q         <= buf_d;
            pt_data_q     <= pt_data_d;
            pt_last_q     <= pt_last_d;
            pt_valid_q    <= pt_valid_d;
            blocks_used_q <= blocks_used_d;
        end
    end

    assign pt_data     = pt_data_q;
    assign pt_last     = pt_last_q;
    assign pt_valid    = pt_valid_q;
    assign blocks_used = blocks_used_q;

endmodule
